// File: rtl/xbar_pkg.sv
// Package xbar_pkg
// Shared definitions for the staged crossbar: port index names, default
// geometry, and the one-hot decode helper used by the legality checks and
// by the input-claim resolution.
//   PORT_PE/W/E/S/N : port index of each router direction
//   DEF_NPORT/DW/CNTW : default crossbar geometry
//   MAX_PORT/IDXW   : widest port vector the decode helper accepts
//   onehot_idx()    : returns {index of the set bit, vector-is-one-hot flag}
package xbar_pkg;

    localparam int PORT_PE = 0;
    localparam int PORT_W  = 1;
    localparam int PORT_E  = 2;
    localparam int PORT_S  = 3;
    localparam int PORT_N  = 4;

    localparam int DEF_NPORT = 5;
    localparam int DEF_DW    = 64;
    localparam int DEF_CNTW  = 16;

    // Grant rows are zero-extended to this width before decoding, so NPORT
    // must not exceed MAX_PORT.
    localparam int MAX_PORT = 16;
    localparam int IDXW     = 4;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic            onehot;
    } onehot_t;

    // Decode a grant row: onehot is set only for exactly one bit set; idx is
    // the position of the highest set bit (meaningful only when onehot=1).
    function automatic onehot_t onehot_idx(input logic [MAX_PORT-1:0] vec);
        onehot_t res;
        res.idx    = {IDXW{1'b0}};
        res.onehot = (vec != {MAX_PORT{1'b0}}) &&
                     ((vec & (vec - {{(MAX_PORT-1){1'b0}}, 1'b1})) == {MAX_PORT{1'b0}});
        for (int k = 0; k < MAX_PORT; k++) begin
            if (vec[k]) begin
                res.idx = IDXW'(k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/xbar_out_stage.sv
// Module xbar_out_stage
// One output column of the staged crossbar: selects the granted input head,
// checks that the grant is legal, holds the packet in a one-entry stage
// register and drains it to the outbuf whenever the outbuf has room.
// Optional feature macro: XBAR_PKT_CNT_EN (saturating enqueue counter).
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   phase_internal  : new accepts allowed only while high
//   in_full/in_pkt  : inbuf valid flags and head packets (all inputs)
//   gnt_row         : this output's grant row, one bit per input
//   claimed         : inputs already taken by a lower-index output
//   outbuf_full     : this output's outbuf cannot take a packet
//   enq/d_in        : enqueue strobe and packet to the outbuf
//   acc             : stage loads the granted packet this cycle
//   row_err         : grant row is non-idle but illegal this cycle
//   pkt_cnt         : enqueue count (zero when the counter is not built)
module xbar_out_stage
    import xbar_pkg::*;
#(
    parameter int NPORT = DEF_NPORT,
    parameter int DW    = DEF_DW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                phase_internal,
    input  logic [NPORT-1:0]    in_full,
    input  logic [NPORT*DW-1:0] in_pkt,
    input  logic [NPORT-1:0]    gnt_row,
    input  logic [NPORT-1:0]    claimed,
    input  logic                outbuf_full,
    output logic                enq,
    output logic [DW-1:0]       d_in,
    output logic                acc,
    output logic                row_err,
    output logic [CNTW-1:0]     pkt_cnt
);

    logic [MAX_PORT-1:0] row_ext_s;
    logic [MAX_PORT-1:0] full_ext_s;
    logic [MAX_PORT-1:0] claim_ext_s;
    onehot_t             sel_s;
    logic                legal_s;
    logic                row_err_s;
    logic [DW-1:0]       pkt_sel_s;
    logic                enq_s;
    logic                acc_s;
    logic                stg_vld_r;
    logic [DW-1:0]       stg_data_r;

    // Widen per-input vectors so the decoded index can address them directly.
    always_comb begin
        row_ext_s              = {MAX_PORT{1'b0}};
        full_ext_s             = {MAX_PORT{1'b0}};
        claim_ext_s            = {MAX_PORT{1'b0}};
        row_ext_s[NPORT-1:0]   = gnt_row;
        full_ext_s[NPORT-1:0]  = in_full;
        claim_ext_s[NPORT-1:0] = claimed;
    end

    // Legality: exactly one input granted, it holds a packet, and no lower
    // output already took it. An all-zero row is idle, not an error.
    always_comb begin
        sel_s     = onehot_idx(row_ext_s);
        legal_s   = sel_s.onehot & full_ext_s[sel_s.idx] & ~claim_ext_s[sel_s.idx];
        row_err_s = (gnt_row != {NPORT{1'b0}}) & ~legal_s;
    end

    // Input mux: AND-OR select; the result is only used when the row is one-hot.
    always_comb begin
        pkt_sel_s = {DW{1'b0}};
        for (int i = 0; i < NPORT; i++) begin
            pkt_sel_s = pkt_sel_s | (in_pkt[i*DW +: DW] & {DW{gnt_row[i]}});
        end
    end

    // Drain ignores phase; accept needs the stage empty or emptying this cycle.
    always_comb begin
        enq_s = reset & stg_vld_r & ~outbuf_full;
        acc_s = reset & phase_internal & legal_s & (~stg_vld_r | enq_s);
    end

    // Stage register: load on accept (also when draining), clear on drain only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stg_vld_r  <= 1'b0;
            stg_data_r <= {DW{1'b0}};
        end else if (acc_s) begin
            stg_vld_r  <= 1'b1;
            stg_data_r <= pkt_sel_s;
        end else if (enq_s) begin
            stg_vld_r  <= 1'b0;
        end else begin
            stg_vld_r  <= stg_vld_r;
        end
    end

    assign enq     = enq_s;
    assign d_in    = stg_data_r;
    assign acc     = acc_s;
    assign row_err = row_err_s;

`ifdef XBAR_PKT_CNT_EN
    logic [CNTW-1:0] cnt_r;

    // Enqueue counter, saturating at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= {CNTW{1'b0}};
        end else if (enq_s && (cnt_r != {CNTW{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign pkt_cnt = cnt_r;
`else
    assign pkt_cnt = {CNTW{1'b0}};
`endif

endmodule

// File: rtl/xbar_staged_param.sv
// Module xbar_staged_param
// Registered crossbar for one VC: moves granted inbuf heads into a
// one-entry stage per output, then into the outbufs one cycle later,
// decoupling arbiter grants from outbuf back-pressure.
// Optional feature macro: XBAR_PKT_CNT_EN (per-output enqueue counters).
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   phase_internal  : 1 = internal phase, new accepts allowed
//   in_full         : inbuf i holds a packet
//   in_pkt          : head packet of inbuf i at [i*DW +: DW]
//   gnt             : gnt[o*NPORT+i] = input i granted output o
//   outbuf_full     : outbuf o cannot take a packet this cycle
//   enq, d_in       : enqueue strobe / packet to outbuf o
//   deq             : dequeue strobe to inbuf i
//   gnt_err         : sticky illegal-grant flag, cleared only by reset
//   pkt_cnt         : per-output enqueue counts (zero when not built)
module xbar_staged_param
    import xbar_pkg::*;
#(
    parameter int NPORT = DEF_NPORT,
    parameter int DW    = DEF_DW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   phase_internal,
    input  logic [NPORT-1:0]       in_full,
    input  logic [NPORT*DW-1:0]    in_pkt,
    input  logic [NPORT*NPORT-1:0] gnt,
    input  logic [NPORT-1:0]       outbuf_full,
    output logic [NPORT-1:0]       enq,
    output logic [NPORT*DW-1:0]    d_in,
    output logic [NPORT-1:0]       deq,
    output logic                   gnt_err,
    output logic [NPORT*CNTW-1:0]  pkt_cnt
);

    logic [NPORT-1:0] claimed_s [NPORT];
    logic [NPORT-1:0] acc_s;
    logic [NPORT-1:0] row_err_s;
    logic [NPORT-1:0] deq_s;
    logic             gnt_err_r;

    // Claim resolution: a one-hot row claims its input for every higher-index
    // output, so a shared input goes only to the lowest-index output.
    always_comb begin
        logic [NPORT-1:0]    claim_run_v;
        logic [MAX_PORT-1:0] row_v;
        onehot_t             dec_v;
        claim_run_v = {NPORT{1'b0}};
        row_v       = {MAX_PORT{1'b0}};
        dec_v       = '0;
        for (int o = 0; o < NPORT; o++) begin
            claimed_s[o]      = claim_run_v;
            row_v             = {MAX_PORT{1'b0}};
            row_v[NPORT-1:0]  = gnt[o*NPORT +: NPORT];
            dec_v             = onehot_idx(row_v);
            if (dec_v.onehot) begin
                claim_run_v = claim_run_v | gnt[o*NPORT +: NPORT];
            end else begin
                claim_run_v = claim_run_v;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NPORT; g++) begin : g_out
            xbar_out_stage #(
                .NPORT (NPORT),
                .DW    (DW),
                .CNTW  (CNTW)
            ) u_stage (
                .clk            (clk),
                .reset          (reset),
                .phase_internal (phase_internal),
                .in_full        (in_full),
                .in_pkt         (in_pkt),
                .gnt_row        (gnt[g*NPORT +: NPORT]),
                .claimed        (claimed_s[g]),
                .outbuf_full    (outbuf_full[g]),
                .enq            (enq[g]),
                .d_in           (d_in[g*DW +: DW]),
                .acc            (acc_s[g]),
                .row_err        (row_err_s[g]),
                .pkt_cnt        (pkt_cnt[g*CNTW +: CNTW])
            );
        end
    endgenerate

    // Dequeue an input when the output it is granted to actually accepts it.
    always_comb begin
        deq_s = {NPORT{1'b0}};
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                deq_s[i] = deq_s[i] | (acc_s[o] & gnt[o*NPORT+i]);
            end
        end
    end

    assign deq = deq_s;

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt_err_r <= 1'b0;
        end else if (row_err_s != {NPORT{1'b0}}) begin
            gnt_err_r <= 1'b1;
        end else begin
            gnt_err_r <= gnt_err_r;
        end
    end

    assign gnt_err = gnt_err_r;

endmodule
